// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit with an iterative (one bit per cycle) shifter.
// Define ALU_FAST_SHIFT_EN to resolve all shifts in a single cycle instead.
module alu_exec_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALU_Ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0010,
    OP_SLL  = 4'b0001,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b0110
  } op_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic            accept;
  logic [SHW-1:0]  sh_amt;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == OP_SLL) || (ctrl == OP_SRL) || (ctrl == OP_SRA);
  endfunction

  function automatic logic [XLEN-1:0] alu_comb(input logic [3:0]      ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    logic [SHW-1:0]  sh;
    sh = b[SHW-1:0];
    case (ctrl)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = XLEN'($signed(a) >>> sh);
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign accept    = in_valid && in_ready;
  assign sh_amt    = src_b[SHW-1:0];

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = ALU_Ctrl;
          cnt_d = sh_amt;
`ifdef ALU_FAST_SHIFT_EN
          result_d = alu_comb(ALU_Ctrl, src_a, src_b);
          state_d  = DONE;
`else
          // Non-zero shifts start from src_a in the working register; a
          // zero-distance shift falls through alu_comb, which yields src_a.
          if (is_shift(ALU_Ctrl) && (sh_amt != '0)) begin
            result_d = src_a;
            state_d  = SHIFT;
          end else begin
            result_d = alu_comb(ALU_Ctrl, src_a, src_b);
            state_d  = DONE;
          end
`endif
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SLL:  result_d = {result_q[XLEN-2:0], 1'b0};
          OP_SRA:  result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
          default: result_d = {1'b0, result_q[XLEN-1:1]};
        endcase
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
// Honours ALU_FAST_SHIFT_EN for expected latencies.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALU_Ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALU_Ctrl  (ALU_Ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned n;
    n = b % 32;
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0100: return a & b;
      4'b0011: return a | b;
      4'b0010: return a ^ b;
      4'b0001: return a << n;
      4'b0101: return a >> n;
      4'b1101: return a[31] ? ~((~a) >> n) : (a >> n);
      4'b0111: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'b0110: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((c == 4'b0001 || c == 4'b0101 || c == 4'b1101) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
`endif
  endfunction

  // Issues one op from IDLE, scrambles inputs after accept, waits for out_valid,
  // then completes the output handshake. Returns observations only.
  task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output int lat,
                       output int busy_ready, output logic ready_at_issue);
    out_ready = 1'b0;
    busy_ready = 0;
    @(negedge clk);
    ready_at_issue = in_ready;
    ALU_Ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ALU_Ctrl = 4'($urandom); src_a = $urandom; src_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ready++;
    r = result;
    z = zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
  endtask

  task automatic check_op(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] r, er;
    logic z, rdy;
    int lat, el, busy;
    er = ref_alu(c, a, b);
    el = ref_lat(c, b);
    do_op(c, a, b, r, z, lat, busy, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL %s ready_at_issue got %b want 1", name, rdy); end
    checks++; if (r !== er) begin errors++; $display("FAIL %s result got %h want %h (ctrl %b a %h b %h)", name, r, er, c, a, b); end
    checks++; if (z !== (er == 32'd0)) begin errors++; $display("FAIL %s zero got %b want %b", name, z, (er == 32'd0)); end
    checks++; if (lat != el) begin errors++; $display("FAIL %s latency got %0d want %0d (ctrl %b b %h)", name, lat, el, c, b); end
    checks++; if (busy != 0) begin errors++; $display("FAIL %s in_ready_while_busy got %0d want 0", name, busy); end
  endtask

  task automatic test_directed;
    check_op("add_5_7",   4'b0000, 32'd5, 32'd7);
    check_op("sub_3_3",   4'b1000, 32'd3, 32'd3);
    check_op("slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'd1);
    check_op("sltu_big",  4'b0110, 32'hFFFF_FFFF, 32'd1);
    check_op("sra_4",     4'b1101, 32'h8000_0000, 32'd4);
    check_op("sll_0",     4'b0001, 32'hDEAD_BEEF, 32'h0000_0020);
    check_op("srl_31",    4'b0101, 32'h8000_0001, 32'd31);
    check_op("sll_1",     4'b0001, 32'hC000_0001, 32'd1);
    check_op("bad_op",    4'b1111, 32'h1234_5678, 32'h1);
  endtask

  task automatic test_random;
    logic [3:0] ops [10] = '{4'b0000, 4'b1000, 4'b0100, 4'b0011, 4'b0010,
                             4'b0001, 4'b0101, 4'b1101, 4'b0111, 4'b0110};
    logic [3:0] c;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      check_op("random", c, a, b);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    ALU_Ctrl = 4'b0000; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b want 1", i, out_valid); end
      checks++; if (result !== 32'd2) begin errors++; $display("FAIL bp_result cycle %0d got %h want 2", i, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    int accepts = 0, dones = 0;
    in_valid = 1'b1; out_ready = 1'b1; ALU_Ctrl = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      src_a = $urandom; src_b = $urandom;
      if (in_ready) accepts++;
      if (out_valid) dones++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (accepts != 10) begin errors++; $display("FAIL b2b_accepts got %0d want 10", accepts); end
    checks++; if (dones != 10) begin errors++; $display("FAIL b2b_dones got %0d want 10", dones); end
  endtask

  task automatic test_reset_mid_shift;
    int stale = 0;
    @(negedge clk);
    ALU_Ctrl = 4'b0001; src_a = 32'h0000_0001; src_b = 32'd31; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pre_valid got %b want 0", out_valid); end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale got %0d want 0", stale); end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ALU_Ctrl = '0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
    test_back_to_back;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
